svc_rv_scoreboard: RTL and testbench



---
 rtl/svc_rv_scoreboard.sv | 108 ++++++++++
 tb/tb_svc_rv_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_scoreboard.sv
// Per-register outstanding-write scoreboard between ID and EX.
// Gates issue on RAW (source pending) and WAW (destination counter cap) conflicts.
module svc_rv_scoreboard #(
  parameter int NUM_RS    = 2,
  parameter int NUM_WB    = 2,
  parameter int MAX_PEND  = 3,
  parameter int WAW_STALL = 0,
  parameter int WB_BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [NUM_RS*5-1:0] issue_rs,
  input  logic [NUM_RS-1:0]   issue_rs_used,
  input  logic [4:0]          issue_rd,
  input  logic                issue_rd_we,
  output logic                issue_ready,
  input  logic [NUM_WB-1:0]   wb_valid,
  input  logic [NUM_WB*5-1:0] wb_rd,
  input  logic [NUM_WB-1:0]   kill_valid,
  input  logic [NUM_WB*5-1:0] kill_rd,
  output logic [NUM_RS-1:0]   hazard_rs,
  output logic                waw_stall,
  output logic [31:0]         pending_mask,
  output logic                busy,
  output logic                err_underflow
);

  localparam int CW = $clog2(MAX_PEND + 1);
  localparam int DW = $clog2(2 * NUM_WB + 1);
  localparam int SW = ((CW > DW) ? CW : DW) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PEND);

  logic [CW-1:0] cnt_q [32];
  logic [CW-1:0] cnt_d [32];
  logic [SW-1:0] avail [32];
  logic [SW-1:0] dec   [32];
  logic [4:0]    rs_id  [NUM_RS];
  logic          wb_hit [NUM_RS];
  logic [CW-1:0] rd_cnt;
  logic [31:0]   pend_d;
  logic          under_d;
  logic          fire;

  // RAW check per source; a writeback retiring the last pending write may bypass.
  always_comb begin
    hazard_rs = '0;
    for (int j = 0; j < NUM_RS; j++) begin
      rs_id[j]  = issue_rs[j*5 +: 5];
      wb_hit[j] = 1'b0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (wb_rd[k*5 +: 5] == rs_id[j])) wb_hit[j] = 1'b1;
      end
      hazard_rs[j] = issue_rs_used[j] && (rs_id[j] != 5'd0) &&
                     (cnt_q[rs_id[j]] != '0) &&
                     !((WB_BYPASS != 0) && (cnt_q[rs_id[j]] == CW'(1)) && wb_hit[j]);
    end
  end

  // Handshake: issue_ready is computed without looking at issue_valid; an
  // instruction is accepted on any cycle where both are high at the clock edge.
  always_comb begin
    rd_cnt      = cnt_q[issue_rd];
    waw_stall   = issue_rd_we && (issue_rd != 5'd0) &&
                  ((rd_cnt == CNT_MAX) || ((WAW_STALL != 0) && (rd_cnt != '0)));
    issue_ready = !(|hazard_rs) && !waw_stall;
    fire        = issue_valid && issue_ready && issue_rd_we && (issue_rd != 5'd0);
  end

  // Net counter update: one possible increment, any number of decrements; clamp at zero.
  always_comb begin
    under_d  = 1'b0;
    pend_d   = '0;
    cnt_d[0] = '0;
    avail[0] = '0;
    dec[0]   = '0;
    for (int r = 1; r < 32; r++) begin
      avail[r] = SW'(cnt_q[r]) + SW'(fire && (issue_rd == 5'(r)));
      dec[r]   = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (wb_rd[k*5 +: 5] == 5'(r)))     dec[r] = dec[r] + SW'(1);
        if (kill_valid[k] && (kill_rd[k*5 +: 5] == 5'(r))) dec[r] = dec[r] + SW'(1);
      end
      if (dec[r] > avail[r]) begin
        cnt_d[r] = '0;
        under_d  = 1'b1;
      end else begin
        cnt_d[r] = CW'(avail[r] - dec[r]);
      end
      pend_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      pending_mask  <= '0;
      busy          <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      pending_mask  <= pend_d;
      busy          <= |pend_d;
      err_underflow <= err_underflow | under_d;
    end
  end

endmodule

// File: tb/tb_svc_rv_scoreboard.sv
// Bench for svc_rv_scoreboard: directed scenarios then random traffic,
// checked against a per-register count model kept as plain integers.
module tb_svc_rv_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [9:0]  issue_rs;
  logic [1:0]  issue_rs_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_we;
  logic        issue_ready;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic [1:0]  kill_valid;
  logic [9:0]  kill_rd;
  logic [1:0]  hazard_rs;
  logic        waw_stall;
  logic [31:0] pending_mask;
  logic        busy;
  logic        err_underflow;

  int mcnt [32];
  bit merr;
  int n_checks = 0;
  int n_err = 0;

  svc_rv_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .kill_valid(kill_valid), .kill_rd(kill_rd),
    .hazard_rs(hazard_rs), .waw_stall(waw_stall), .pending_mask(pending_mask),
    .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd, input bit we,
                       input logic [1:0] wbv, input logic [4:0] w0, input logic [4:0] w1,
                       input logic [1:0] kv, input logic [4:0] k0, input logic [4:0] k1);
    issue_valid   = v;
    issue_rs      = {rs1, rs0};
    issue_rs_used = used;
    issue_rd      = rd;
    issue_rd_we   = we;
    wb_valid      = wbv;
    wb_rd         = {w1, w0};
    kill_valid    = kv;
    kill_rd       = {k1, k0};
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    merr = 0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(input string tag);
    logic [1:0]  exp_hz;
    logic        exp_waw, exp_rdy;
    logic [31:0] exp_mask;
    logic [4:0]  rs, w, kr;
    bit          hit;
    int          delta [32];
    #1;
    for (int j = 0; j < 2; j++) begin
      rs  = (j == 0) ? issue_rs[4:0] : issue_rs[9:5];
      hit = (wb_valid[0] && wb_rd[4:0] == rs) || (wb_valid[1] && wb_rd[9:5] == rs);
      exp_hz[j] = issue_rs_used[j] && rs != 0 && mcnt[rs] != 0 && !(mcnt[rs] == 1 && hit);
    end
    exp_waw = issue_rd_we && issue_rd != 0 && mcnt[issue_rd] == 3;
    exp_rdy = (exp_hz == 2'b00) && !exp_waw;
    chk({tag, ".hazard_rs"}, 32'(hazard_rs), 32'(exp_hz));
    chk({tag, ".waw_stall"}, 32'(waw_stall), 32'(exp_waw));
    chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(exp_rdy));
    for (int i = 0; i < 32; i++) delta[i] = 0;
    if (issue_valid && exp_rdy && issue_rd_we && issue_rd != 0) delta[issue_rd]++;
    for (int k = 0; k < 2; k++) begin
      w  = (k == 0) ? wb_rd[4:0] : wb_rd[9:5];
      kr = (k == 0) ? kill_rd[4:0] : kill_rd[9:5];
      if (wb_valid[k] && w != 0) delta[w]--;
      if (kill_valid[k] && kr != 0) delta[kr]--;
    end
    @(posedge clk);
    exp_mask = '0;
    for (int i = 1; i < 32; i++) begin
      mcnt[i] = mcnt[i] + delta[i];
      if (mcnt[i] < 0) begin
        mcnt[i] = 0;
        merr = 1;
      end
      exp_mask[i] = (mcnt[i] != 0);
    end
    #1;
    chk({tag, ".pending_mask"}, pending_mask, exp_mask);
    chk({tag, ".busy"}, 32'(busy), 32'(exp_mask != 0));
    chk({tag, ".err_underflow"}, 32'(err_underflow), 32'(merr));
    @(negedge clk);
  endtask

  initial begin
    int tmp [32];
    logic [4:0] r;
    logic [1:0] wbv, kv;
    logic [4:0] w [2];
    logic [4:0] kr [2];

    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.pending_mask", pending_mask, 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.err", 32'(err_underflow), 32'h0);
    chk("rst.issue_ready", 32'(issue_ready), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW on x10, then bypassed by a same-cycle writeback
    drive(1, 0, 0, 2'b00, 10, 1, 2'b00, 0, 0, 2'b00, 0, 0); step("raw.issue10");
    drive(1, 10, 0, 2'b01, 11, 0, 2'b00, 0, 0, 2'b00, 0, 0); step("raw.stall");
    chk("raw.hz_const", 32'(hazard_rs), 32'h1);
    drive(1, 10, 0, 2'b01, 11, 0, 2'b01, 10, 0, 2'b00, 0, 0); step("raw.bypass");
    chk("raw.mask10", 32'(pending_mask[10]), 32'h0);

    // WAW cap on x7
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 2'b00, 7, 1, 2'b00, 0, 0, 2'b00, 0, 0); step("cap.fill");
    end
    drive(1, 0, 0, 2'b00, 7, 1, 2'b00, 0, 0, 2'b00, 0, 0); step("cap.full");
    drive(1, 0, 0, 2'b00, 7, 1, 2'b01, 7, 0, 2'b00, 0, 0); step("cap.wb");
    drive(1, 0, 0, 2'b00, 7, 1, 2'b00, 0, 0, 2'b00, 0, 0); step("cap.accept");
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11, 7, 7, 2'b00, 0, 0); step("cap.drain2");
    drive(0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b01, 7, 0); step("cap.kill");

    // Same-cycle issue and writeback on x4, then kill
    drive(1, 0, 0, 2'b00, 4, 1, 2'b00, 0, 0, 2'b00, 0, 0); step("net.issue4");
    drive(1, 0, 0, 2'b00, 4, 1, 2'b10, 0, 4, 2'b00, 0, 0); step("net.same");
    chk("net.mask4", 32'(pending_mask[4]), 32'h1);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b10, 0, 4); step("net.kill4");
    chk("net.busy0", 32'(busy), 32'h0);

    // x0 traffic is ignored
    drive(1, 0, 0, 2'b01, 0, 1, 2'b01, 0, 0, 2'b00, 0, 0); step("x0");
    chk("x0.mask", pending_mask, 32'h0);

    // Underflow on x3, sticky until reset
    drive(1, 0, 0, 2'b00, 3, 1, 2'b00, 0, 0, 2'b00, 0, 0); step("uf.issue3");
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11, 3, 3, 2'b00, 0, 0); step("uf.double");
    chk("uf.err", 32'(err_underflow), 32'h1);
    idle(); step("uf.hold1");
    idle(); step("uf.hold2");

    // Mid-stream asynchronous reset with cnt[5]=2
    drive(1, 0, 0, 2'b00, 5, 1, 2'b00, 0, 0, 2'b00, 0, 0); step("mr.issue5a");
    drive(1, 0, 0, 2'b00, 5, 1, 2'b00, 0, 0, 2'b00, 0, 0); step("mr.issue5b");
    drive(0, 5, 0, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mr.pending_mask", pending_mask, 32'h0);
    chk("mr.busy", 32'(busy), 32'h0);
    chk("mr.err", 32'(err_underflow), 32'h0);
    chk("mr.issue_ready", 32'(issue_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 2'b00, 5, 1, 2'b00, 0, 0, 2'b00, 0, 0); step("mr.reissue5");
    chk("mr.mask5", 32'(pending_mask[5]), 32'h1);

    // Random traffic on x0..x7; completions only target registers with pending writes
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 32; i++) tmp[i] = mcnt[i];
      for (int k = 0; k < 2; k++) begin
        r = 5'($urandom_range(0, 7));
        wbv[k] = ($urandom_range(0, 9) < 6) && tmp[r] > 0;
        if (wbv[k]) tmp[r]--;
        w[k] = r;
        r = 5'($urandom_range(0, 7));
        kv[k] = ($urandom_range(0, 9) < 2) && tmp[r] > 0;
        if (kv[k]) tmp[r]--;
        kr[k] = r;
      end
      drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            wbv, w[0], w[1], kv, kr[0], kr[1]);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
